// File: rtl/unidade_mult_div.sv
// unidade_mult_div: iterative MULT/MULTU/DIV/DIVU unit, one bit per clock; divide built only with MULTDIV_DIV_EN
module unidade_mult_div #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;
  state_t state, state_n;
  logic [5:0] cnt;
  logic neg_q, accept, zero_div;
  logic [WIDTH-1:0] m, abs_a, abs_b;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] acc, acc_n, mul_res, res;
`ifdef MULTDIV_DIV_EN
  logic div_q, nrem_q, zero_q, no_borrow;
  logic [WIDTH-1:0] diff, quo, rem;
  assign accept = start && state == IDLE;
  assign zero_div = op[1] && operand_b == '0;
`else
  assign accept = start && state == IDLE && !op[1];
  assign zero_div = 1'b0;
  assign div_by_zero = 1'b0;
`endif
  assign busy = state != IDLE;
  assign abs_a = (op[0] && operand_a[WIDTH-1]) ? -operand_a : operand_a;
  assign abs_b = (op[0] && operand_b[WIDTH-1]) ? -operand_b : operand_b;
  // state register
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  // next state: a zero divisor skips straight to the write-back state
  always_comb begin
    state_n = (state == IDLE && accept) ? (zero_div ? SIGN : CALC) :
              (state == CALC && cnt == 6'(WIDTH-1)) ? SIGN :
              (state == SIGN) ? IDLE : state;
  end
  // one iteration: shift-add multiply (LSB first) or restoring divide step
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? m : {WIDTH{1'b0}}};
    acc_n = {sum, acc[WIDTH-1:1]};
`ifdef MULTDIV_DIV_EN
    diff = acc[2*WIDTH-2:WIDTH-1] - m;
    no_borrow = acc[2*WIDTH-1] | (acc[2*WIDTH-2:WIDTH-1] >= m);
    acc_n = div_q ? {no_borrow ? diff : acc[2*WIDTH-2:WIDTH-1], acc[WIDTH-2:0], no_borrow} : acc_n;
`endif
  end
  // sign correction of the magnitude result; a zero divide passes the preloaded pair through
  always_comb begin
    mul_res = neg_q ? -acc : acc;
    res = mul_res;
`ifdef MULTDIV_DIV_EN
    rem = nrem_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    quo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    res = zero_q ? acc : div_q ? {rem, quo} : mul_res;
`endif
  end
  // datapath and registered outputs
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      neg_q <= 1'b0;
      m <= '0;
      acc <= '0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
`ifdef MULTDIV_DIV_EN
      div_q <= 1'b0;
      nrem_q <= 1'b0;
      zero_q <= 1'b0;
      div_by_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        cnt <= '0;
        neg_q <= op[0] & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
        m <= op[1] ? abs_b : abs_a;
        acc <= zero_div ? {operand_a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, op[1] ? abs_a : abs_b};
`ifdef MULTDIV_DIV_EN
        div_q <= op[1];
        nrem_q <= op[0] & operand_a[WIDTH-1];
        zero_q <= zero_div;
        div_by_zero <= 1'b0;
`endif
      end else if (state == CALC) begin
        acc <= acc_n;
        cnt <= cnt + 6'd1;
      end else if (state == SIGN) begin
        {hi, lo} <= res;
        done <= 1'b1;
`ifdef MULTDIV_DIV_EN
        div_by_zero <= zero_q;
`endif
      end
    end
endmodule

// File: tb/tb_unidade_mult_div.sv
// tb_unidade_mult_div: directed self-checking bench for unidade_mult_div
module tb_unidade_mult_div;
  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] operand_a = '0, operand_b = '0;
  logic busy, done, div_by_zero;
  logic [31:0] hi, lo;
  int errors = 0, checks = 0;
  int lat, bcnt;

  unidade_mult_div #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drive a one-cycle start; returns at the falling edge right after the accepting edge
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // counts falling edges until done (lat = -1 on timeout) and busy-high cycles seen
  task automatic wait_done(input int bound, output int l, output int b);
    bit hit = 0;
    l = -1; b = 0;
    for (int n = 0; n <= bound && !hit; n++) begin
      if (busy) b++;
      if (done) begin l = n; hit = 1; end
      else @(negedge clock);
    end
  endtask

  initial begin
    @(negedge clock);
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hilo", {hi, lo}, 64'h0);
    chk("rst_dbz", div_by_zero, 0);
    reset_n = 1'b1;

    launch(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(60, lat, bcnt);
    chk("multu_lat", lat, 33);
    chk("multu_busy", bcnt, 33);
    chk("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
    @(negedge clock);
    chk("multu_pulse", done, 0);

    launch(2'b01, 32'hFFFFFFFD, 32'd7);
    wait_done(60, lat, bcnt);
    chk("mult_lat", lat, 33);
    chk("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);

`ifdef MULTDIV_DIV_EN
    launch(2'b11, 32'hFFFFFFF9, 32'd2);
    wait_done(60, lat, bcnt);
    chk("div_neg_lat", lat, 33);
    chk("div_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

    launch(2'b11, 32'h80000000, 32'hFFFFFFFF);
    wait_done(60, lat, bcnt);
    chk("div_ovf_hilo", {hi, lo}, 64'h00000000_80000000);

    launch(2'b10, 32'd100, 32'd7);
    wait_done(60, lat, bcnt);
    chk("divu_hilo", {hi, lo}, {32'd2, 32'd14});

    launch(2'b10, 32'h12345678, 32'd0);
    wait_done(60, lat, bcnt);
    chk("dbz_lat", lat, 1);
    chk("dbz_hilo", {hi, lo}, 64'h12345678_FFFFFFFF);
    chk("dbz_flag", div_by_zero, 1);
    @(negedge clock);
    chk("dbz_hold", div_by_zero, 1);

    launch(2'b00, 32'd3, 32'd4);
    chk("dbz_clear", div_by_zero, 0);
    wait_done(60, lat, bcnt);
    chk("multu_small", {hi, lo}, 64'd12);
`else
    launch(2'b10, 32'd100, 32'd7);
    wait_done(40, lat, bcnt);
    chk("nodiv_done", lat, -1);
    chk("nodiv_busy", bcnt, 0);
    chk("nodiv_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    chk("nodiv_dbz", div_by_zero, 0);
`endif

    launch(2'b01, 32'd5, 32'hFFFFFFFA);
    repeat (10) @(negedge clock);
    op = 2'b00; operand_a = 32'd2; operand_b = 32'd2; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(60, lat, bcnt);
    chk("busy_start_lat", lat, 22);
    chk("busy_start_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFE2);
    repeat (3) @(negedge clock);
    chk("busy_start_noqueue", busy, 0);

    launch(2'b00, 32'd9, 32'd9);
    wait_done(60, lat, bcnt);
    chk("b2b_first", {hi, lo}, 64'd81);
    op = 2'b00; operand_a = 32'd6; operand_b = 32'd7; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    wait_done(60, lat, bcnt);
    chk("b2b_lat", lat, 33);
    chk("b2b_hilo", {hi, lo}, 64'd42);

    launch(2'b01, 32'd11, 32'd13);
    repeat (20) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_hilo", {hi, lo}, 64'h0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    chk("abort_idle", {busy, done}, 2'b00);
    chk("abort_nowrite", {hi, lo}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
